// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: instruction-fetch stage with a DEPTH-entry prefetch queue.
// Fetches one word per cycle from a combinational imem port, queues
// {fetch address + PC_STEP, instruction} pairs and hands them to decode
// through a valid/ready handshake. A taken branch flushes and redirects.
module fetch_queue_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         freeze,
  input  logic                         branchTaken,
  input  logic [ADDR_WIDTH-1:0]        branchAddress,
  output logic [ADDR_WIDTH-1:0]        imemAddr,
  output logic                         imemReq,
  input  logic [INST_WIDTH-1:0]        imemInst,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [ADDR_WIDTH-1:0]        PC,
  output logic [INST_WIDTH-1:0]        Instruction,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_WIDTH + INST_WIDTH;
  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(PC_STEP);

  logic [ADDR_WIDTH-1:0] fetch_pc_reg;
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic [EW-1:0]         entry_reg [DEPTH];

  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] fetch_pc_next;
  logic [EW-1:0]         head;

  assign fetch_pc_next = fetch_pc_reg + STEP_C;

  // Handshake and fetch-fire decode; a branch kills both push and pop.
  always_comb begin
    outValid = (count_reg != '0) && !branchTaken;
    pop      = outValid && outReady;
    imemReq  = !rst && !branchTaken && !freeze && ((count_reg < DEPTH_C) || pop);
    push     = imemReq;
  end

  assign imemAddr = fetch_pc_reg;
  assign count    = count_reg;
  assign head     = entry_reg[rd_ptr_reg];

  // Head entry is only shown while it is valid; otherwise outputs read zero.
  always_comb begin
    PC          = '0;
    Instruction = '0;
    if (outValid) begin
      PC          = head[EW-1:INST_WIDTH];
      Instruction = head[INST_WIDTH-1:0];
    end
  end

  // Queue storage: each slot captures the fetched pair when the write pointer selects it.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PW'(gi)))
          entry_reg[gi] <= {fetch_pc_next, imemInst};
      end
    end
  endgenerate

  // Fetch PC, pointers and occupancy; reset beats branch, branch beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else if (branchTaken) begin
      fetch_pc_reg <= branchAddress;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      if (push) begin
        fetch_pc_reg <= fetch_pc_next;
        wr_ptr_reg   <= wr_ptr_reg + 1'b1;
      end
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

endmodule
